// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// operand width and the bit positions used on the TinyTapeout pin map.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH = 4;

    localparam int UIO_START_BIT = 0;
    localparam int UIO_CLEAR_BIT = 1;

    localparam int UO_BUSY_BIT = 5;
    localparam int UO_DONE_BIT = 6;

endpackage

// File: rtl/ha_cell.sv
// Single half-adder cell; two of these plus an OR make the serial full adder.
module ha_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/tt_um_kavinmalar_serial_add_ctrl.sv
// Bit-serial unsigned adder: captures two 4-bit operands on start, adds one
// bit per enabled cycle LSB-first, and presents a 5-bit result with busy/done.
module tt_um_kavinmalar_serial_add_ctrl #(
    parameter int WIDTH = serial_add_pkg::WIDTH,
    parameter int CW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import serial_add_pkg::*;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_idx;
    logic [WIDTH:0]   r_result;

    logic w_start;
    logic w_clear;
    logic w_s1;
    logic w_c1;
    logic w_sum;
    logic w_c2;
    logic w_cout;
    logic w_last;
    logic w_unused;

    assign w_start  = uio_in[UIO_START_BIT];
    assign w_clear  = uio_in[UIO_CLEAR_BIT];
    assign w_unused = &{1'b0, uio_in[7:2]};

    ha_cell u_ha0 (
        .i_a     (r_a[0]),
        .i_b     (r_b[0]),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    ha_cell u_ha1 (
        .i_a     (w_s1),
        .i_b     (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_c2)
    );

    assign w_cout = w_c1 | w_c2;
    assign w_last = (r_idx == CW'(WIDTH - 1));

    // Sum bits enter at the top of the accumulator so the first (LSB) bit
    // has drifted down to bit 0 once all WIDTH bits have been produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
        end else if (ena) begin
            if (w_clear) begin
                r_state  <= ST_IDLE;
                r_a      <= '0;
                r_b      <= '0;
                r_acc    <= '0;
                r_carry  <= 1'b0;
                r_idx    <= '0;
                r_result <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_a     <= ui_in[WIDTH-1:0];
                            r_b     <= ui_in[2*WIDTH-1:WIDTH];
                            r_acc   <= '0;
                            r_carry <= 1'b0;
                            r_idx   <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_carry <= w_cout;
                        r_idx   <= r_idx + CW'(1);
                        if (w_last) begin
                            r_result <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // Four-phase handshake: a held start cannot relaunch.
                        if (!w_start) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        uo_out              = '0;
        uo_out[WIDTH:0]     = r_result;
        uo_out[UO_BUSY_BIT] = (r_state == ST_RUN);
        uo_out[UO_DONE_BIT] = (r_state == ST_DONE);
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_kavinmalar_serial_add_ctrl.sv
// Scoreboard bench for the serial adder: expected results are queued at
// launch and popped by a monitor on each rising edge of done.
module tb_tt_um_kavinmalar_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int last_res = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    tt_um_kavinmalar_serial_add_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one pop per completed operation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && uo_out[6] === 1'b1 && prev_done === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {27'd0, uo_out[4:0]}, 32'hFFFF_FFFF);
            end else begin
                chk("result", {27'd0, uo_out[4:0]}, exp_q.pop_front());
                chk("bit7_zero", {31'd0, uo_out[7]}, 0);
            end
        end
        prev_done = uo_out[6];
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp, input int gap);
        int   busy_n = 0;
        logic seen   = 1'b0;
        logic oe_bad = 1'b0;
        @(posedge clk); #2;
        ui_in  = {b, a};
        uio_in = 8'h01;
        exp_q.push_back(exp);
        @(posedge clk); #2;
        uio_in = 8'h00;
        ui_in  = 8'hFF;
        chk("hold_in_run", {27'd0, uo_out[4:0]}, last_res);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (uio_oe !== 8'h00) oe_bad = 1'b1;
            if (uo_out[6] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (uo_out[5] === 1'b1) busy_n++;
            if (gap > 0 && k == 1) ena = 1'b0;
            if (gap > 0 && k == 1 + gap) ena = 1'b1;
        end
        ena = 1'b1;
        chk("done_seen", {31'd0, seen}, 1);
        chk("busy_cycles", busy_n, 4 + gap);
        chk("uio_oe_zero", {31'd0, oe_bad}, 0);
        last_res = exp;
        @(posedge clk); #2;
        chk("back_idle", {30'd0, uo_out[6:5]}, 0);
        chk("result_held", {27'd0, uo_out[4:0]}, exp);
    endtask

    initial begin
        logic seen;
        int   bad;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        chk("reset_uo_out", uo_out, 0);
        chk("reset_uio_out", uio_out, 0);
        chk("reset_uio_oe", uio_oe, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(4'd0,  4'd0,  0,  0);
        run_op(4'd15, 4'd15, 30, 0);
        run_op(4'd9,  4'd7,  16, 0);

        // start held high through DONE
        @(posedge clk); #2;
        ui_in  = {4'd4, 4'd3};
        uio_in = 8'h01;
        exp_q.push_back(7);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (uo_out[6] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("held_done_seen", {31'd0, seen}, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (uo_out[6] !== 1'b1 || uo_out[5] !== 1'b0) bad++;
        end
        chk("held_done_stays", bad, 0);
        @(posedge clk); #2;
        uio_in = 8'h00;
        @(posedge clk); #2;
        chk("held_back_idle", {30'd0, uo_out[6:5]}, 0);
        chk("held_result", {27'd0, uo_out[4:0]}, 7);
        last_res = 7;

        // clear together with start during RUN
        @(posedge clk); #2;
        ui_in  = {4'd9, 4'd9};
        uio_in = 8'h01;
        @(posedge clk); #2;
        @(posedge clk); #2;
        uio_in = 8'h03;
        @(posedge clk); #2;
        chk("clear_uo_out", uo_out, 0);
        uio_in = 8'h00;
        repeat (8) @(posedge clk);
        #2;
        chk("clear_no_done", {30'd0, uo_out[6:5]}, 0);
        last_res = 0;

        // asynchronous reset mid-RUN
        @(posedge clk); #2;
        ui_in  = {4'd12, 4'd12};
        uio_in = 8'h01;
        @(posedge clk); #2;
        uio_in = 8'h00;
        @(posedge clk); #2;
        chk("run_busy_before_rst", {31'd0, uo_out[5]}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", uo_out, 0);
        #3 rst_n = 1'b1;
        last_res = 0;
        run_op(4'd5, 4'd6, 11, 0);

        // ena low for 3 cycles mid-RUN
        run_op(4'd10, 4'd5, 15, 3);

        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
